// File: rtl/util_pkg.sv
// Shared instruction-cache types, geometry constants and address-split helpers.
package util_pkg;

    localparam int PC_BITS      = 32;
    localparam int FETCH_WIDTH  = 64;
    localparam int INSTR_BITS   = 32;
    localparam int ICACHE_LINES = 16;
    localparam int OFF_BITS     = 3;
    localparam int IDX_BITS     = $clog2(ICACHE_LINES);
    localparam int TAG_BITS     = PC_BITS - IDX_BITS - OFF_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } icache_state_e;

    typedef struct packed {
        logic               valid;
        logic [PC_BITS-1:0] addr;
    } icache_req_s;

    typedef struct packed {
        logic                   valid;
        logic                   miss;
        logic                   partial;
        logic [PC_BITS-1:0]     pc;
        logic [FETCH_WIDTH-1:0] data;
    } icache_resp_s;

    typedef struct packed {
        logic                   valid;
        logic [TAG_BITS-1:0]    tag;
        logic [FETCH_WIDTH-1:0] data;
    } icache_line_s;

    function automatic logic [IDX_BITS-1:0] idx_of(input logic [PC_BITS-1:0] a);
        return a[OFF_BITS +: IDX_BITS];
    endfunction

    function automatic logic [TAG_BITS-1:0] tag_of(input logic [PC_BITS-1:0] a);
        return a[PC_BITS-1 -: TAG_BITS];
    endfunction

    function automatic logic [PC_BITS-1:0] line_addr(input logic [PC_BITS-1:0] a);
        return {a[PC_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/icache_responder_if.sv
// Fetch-side and refill-side signal bundle of the instruction-cache responder.
interface icache_responder_if;
    import util_pkg::*;

    logic                   req_valid_i;
    logic [PC_BITS-1:0]     req_addr_i;
    logic                   flush_i;
    logic                   inv_all_i;
    logic                   resp_valid_o;
    logic                   resp_miss_o;
    logic [PC_BITS-1:0]     resp_pc_o;
    logic [FETCH_WIDTH-1:0] resp_data_o;
    logic                   resp_partial_o;
    logic                   mem_req_valid_o;
    logic [PC_BITS-1:0]     mem_req_addr_o;
    logic                   mem_req_ready_i;
    logic                   mem_resp_valid_i;
    logic [FETCH_WIDTH-1:0] mem_resp_data_i;

    modport slave (
        input  req_valid_i, req_addr_i, flush_i, inv_all_i,
        input  mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        output resp_valid_o, resp_miss_o, resp_pc_o, resp_data_o, resp_partial_o,
        output mem_req_valid_o, mem_req_addr_o
    );

    modport master (
        output req_valid_i, req_addr_i, flush_i, inv_all_i,
        output mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
        input  resp_valid_o, resp_miss_o, resp_pc_o, resp_data_o, resp_partial_o,
        input  mem_req_valid_o, mem_req_addr_o
    );

endinterface

// File: rtl/icache_line_array.sv
// Direct-mapped tag/data/valid storage: one combinational read port, one write
// port and a clear-all for the valid bits (clear wins over a same-edge write).
module icache_line_array
    import util_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_all_i,
    input  logic [IDX_BITS-1:0]    rd_idx_i,
    output icache_line_s           rd_line_o,
    input  logic                   wr_en_i,
    input  logic [IDX_BITS-1:0]    wr_idx_i,
    input  logic [TAG_BITS-1:0]    wr_tag_i,
    input  logic [FETCH_WIDTH-1:0] wr_data_i
);

    logic [ICACHE_LINES-1:0] valid_q;
    logic [ICACHE_LINES-1:0] valid_d;
    logic [TAG_BITS-1:0]     tag_q  [ICACHE_LINES];
    logic [FETCH_WIDTH-1:0]  data_q [ICACHE_LINES];

    always_comb begin
        valid_d = valid_q;
        if (clr_all_i) begin
            valid_d = '0;
        end else if (wr_en_i) begin
            valid_d[wr_idx_i] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload needs no reset: it is only ever observed behind its valid bit.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            data_q[wr_idx_i] <= wr_data_i;
        end
    end

    always_comb begin
        rd_line_o       = '0;
        rd_line_o.valid = valid_q[rd_idx_i];
        rd_line_o.tag   = tag_q[rd_idx_i];
        rd_line_o.data  = data_q[rd_idx_i];
    end

endmodule

// File: rtl/icache_responder.sv
// Answers each fetch one cycle later with a hit or a miss and runs a
// single-outstanding refill toward lower memory.
module icache_responder
    import util_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    icache_responder_if.slave   bus
);

    icache_state_e      state_q, state_d;
    logic [PC_BITS-1:0] fill_addr_q, fill_addr_d;
    logic               poison_q, poison_d;
    icache_resp_s       resp_q, resp_d;
    icache_req_s        req_s;
    icache_line_s       rd_line_s;
    logic               lookup_s;
    logic               hit_s;
    logic               wr_en_s;

    assign req_s.valid = bus.req_valid_i;
    assign req_s.addr  = bus.req_addr_i;
    assign lookup_s    = req_s.valid && !bus.flush_i;
    assign hit_s       = rd_line_s.valid && (rd_line_s.tag == tag_of(req_s.addr));
    // A same-edge invalidate must also block the install.
    assign wr_en_s     = (state_q == WAIT) && bus.mem_resp_valid_i && !poison_q && !bus.inv_all_i;

    icache_line_array u_array (
        .clk       (clk),
        .rst       (rst),
        .clr_all_i (bus.inv_all_i),
        .rd_idx_i  (idx_of(req_s.addr)),
        .rd_line_o (rd_line_s),
        .wr_en_i   (wr_en_s),
        .wr_idx_i  (idx_of(fill_addr_q)),
        .wr_tag_i  (tag_of(fill_addr_q)),
        .wr_data_i (bus.mem_resp_data_i)
    );

    always_comb begin
        resp_d = '0;
        if (lookup_s) begin
            resp_d.pc = req_s.addr;
            if (hit_s) begin
                resp_d.valid   = 1'b1;
                resp_d.partial = req_s.addr[2];
                if (req_s.addr[2]) begin
                    resp_d.data = {{(FETCH_WIDTH-INSTR_BITS){1'b0}},
                                   rd_line_s.data[FETCH_WIDTH-1 -: INSTR_BITS]};
                end else begin
                    resp_d.data = rd_line_s.data;
                end
            end else begin
                resp_d.miss = 1'b1;
            end
        end else begin
            resp_d = '0;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_addr_d = fill_addr_q;
        if (bus.inv_all_i && (state_q != IDLE)) begin
            poison_d = 1'b1;
        end else begin
            poison_d = poison_q;
        end
        case (state_q)
            IDLE: begin
                if (lookup_s && !hit_s) begin
                    state_d     = REQ;
                    fill_addr_d = line_addr(req_s.addr);
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_req_ready_i) begin
                    state_d = WAIT;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (bus.mem_resp_valid_i) begin
                    state_d  = IDLE;
                    poison_d = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d  = IDLE;
                poison_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fill_addr_q <= '0;
            poison_q    <= 1'b0;
            resp_q      <= '0;
        end else begin
            state_q     <= state_d;
            fill_addr_q <= fill_addr_d;
            poison_q    <= poison_d;
            resp_q      <= resp_d;
        end
    end

    assign bus.resp_valid_o    = resp_q.valid;
    assign bus.resp_miss_o     = resp_q.miss;
    assign bus.resp_partial_o  = resp_q.partial;
    assign bus.resp_pc_o       = resp_q.pc;
    assign bus.resp_data_o     = resp_q.data;
    assign bus.mem_req_valid_o = (state_q == REQ);
    assign bus.mem_req_addr_o  = fill_addr_q;

endmodule

// File: tb/tb_icache_responder.sv
// Directed scoreboard bench for icache_responder: expected responses are queued
// when a fetch is driven and compared against the registered response.
module tb_icache_responder;
    import util_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    icache_responder_if bus();
    icache_responder dut (.clk(clk), .rst(rst), .bus(bus));

    icache_resp_s exp_q[$];
    int checks = 0;
    int errors = 0;

    localparam logic [63:0] D1 = 64'h0000_0013_0000_0093;
    localparam logic [63:0] D2 = 64'hAAAA_AAAA_BBBB_BBBB;
    localparam logic [63:0] D3 = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D4 = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D5 = 64'hDEAD_BEEF_CAFE_F00D;
    localparam logic [63:0] DJ = 64'hFFFF_0000_FFFF_0000;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; compare the response against the scoreboard head (or idle zeros).
    task automatic cycle();
        icache_resp_s e;
        @(posedge clk);
        #1;
        e = '0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk("resp_valid",   64'(bus.resp_valid_o),   64'(e.valid));
        chk("resp_miss",    64'(bus.resp_miss_o),    64'(e.miss));
        chk("resp_partial", 64'(bus.resp_partial_o), 64'(e.partial));
        chk("resp_pc",      64'(bus.resp_pc_o),      64'(e.pc));
        chk("resp_data",    bus.resp_data_o,         e.data);
    endtask

    task automatic fetch(input logic [31:0] a, input logic fl, input logic v,
                         input logic m, input logic p, input logic [63:0] d);
        icache_resp_s e;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        bus.flush_i     = fl;
        e.valid   = v;
        e.miss    = m;
        e.partial = p;
        e.pc      = fl ? 32'h0 : a;
        e.data    = d;
        exp_q.push_back(e);
        cycle();
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic hit(input logic [31:0] a, input logic [63:0] line);
        logic [63:0] d;
        d = a[2] ? {32'h0, line[63:32]} : line;
        fetch(a, 1'b0, 1'b1, 1'b0, a[2], d);
    endtask

    task automatic miss(input logic [31:0] a);
        fetch(a, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    endtask

    task automatic flushed(input logic [31:0] a);
        fetch(a, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0);
    endtask

    // Accept the pending refill request, wait, then return one line.
    task automatic refill(input logic [31:0] a, input logic [63:0] d, input int gap);
        chk("mem_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
        chk("mem_req_addr",  64'(bus.mem_req_addr_o),  64'(a));
        bus.mem_req_ready_i = 1'b1;
        cycle();
        bus.mem_req_ready_i = 1'b0;
        chk("mem_req_drop", 64'(bus.mem_req_valid_o), 64'd0);
        repeat (gap) cycle();
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = d;
        cycle();
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = 64'h0;
    endtask

    initial begin
        rst                  = 1'b1;
        bus.req_valid_i      = 1'b0;
        bus.req_addr_i       = 32'h0;
        bus.flush_i          = 1'b0;
        bus.inv_all_i        = 1'b0;
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b0;
        bus.mem_resp_data_i  = 64'h0;
        repeat (2) cycle();
        chk("rst_mem_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        chk("rst_mem_req_addr",  64'(bus.mem_req_addr_o),  64'd0);
        rst = 1'b0;

        // Cold miss, refill, hit; then upper-half partial access.
        miss(32'h0000_1000);
        refill(32'h0000_1000, D1, 2);
        hit(32'h0000_1000, D1);
        hit(32'h0000_1004, D1);

        // Conflict eviction on index 0.
        miss(32'h0000_1080);
        refill(32'h0000_1080, D2, 1);
        hit(32'h0000_1080, D2);
        miss(32'h0000_1000);
        refill(32'h0000_1000, D1, 0);
        hit(32'h0000_1000, D1);

        // Flush kills a hit response and a missing request never refills.
        flushed(32'h0000_1000);
        flushed(32'h0000_2000);
        chk("flush_no_refill", 64'(bus.mem_req_valid_o), 64'd0);
        cycle();
        chk("flush_no_refill2", 64'(bus.mem_req_valid_o), 64'd0);

        // Invalidate while in WAIT poisons the returning line.
        miss(32'h0000_3000);
        bus.mem_req_ready_i = 1'b1;
        cycle();
        bus.mem_req_ready_i = 1'b0;
        bus.inv_all_i = 1'b1;
        cycle();
        bus.inv_all_i = 1'b0;
        cycle();
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = D3;
        cycle();
        bus.mem_resp_valid_i = 1'b0;
        miss(32'h0000_3000);
        refill(32'h0000_3000, D3, 0);
        hit(32'h0000_3000, D3);
        // Lookup coinciding with invalidate sees pre-invalidate state.
        bus.inv_all_i = 1'b1;
        hit(32'h0000_3004, D3);
        bus.inv_all_i = 1'b0;
        miss(32'h0000_3000);
        refill(32'h0000_3000, D4, 0);
        hit(32'h0000_3000, D4);
        miss(32'h0000_1000);

        // Busy misses while the 0x1000 request is stalled for 5 cycles.
        for (int i = 0; i < 5; i++) begin
            miss(32'h0000_4000);
            chk("busy_req_valid", 64'(bus.mem_req_valid_o), 64'd1);
            chk("busy_req_addr",  64'(bus.mem_req_addr_o),  64'h1000);
        end
        refill(32'h0000_1000, D1, 1);
        chk("busy_idle", 64'(bus.mem_req_valid_o), 64'd0);
        hit(32'h0000_1000, D1);

        // Invalidate coinciding with refill data: line not installed.
        miss(32'h0000_5000);
        bus.mem_req_ready_i = 1'b1;
        cycle();
        bus.mem_req_ready_i  = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = D5;
        bus.inv_all_i        = 1'b1;
        cycle();
        bus.mem_resp_valid_i = 1'b0;
        bus.inv_all_i        = 1'b0;
        miss(32'h0000_5000);
        refill(32'h0000_5000, D5, 0);
        hit(32'h0000_5000, D5);

        // Stray refill data in IDLE is ignored.
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = DJ;
        cycle();
        bus.mem_resp_valid_i = 1'b0;
        hit(32'h0000_5000, D5);

        // Asynchronous reset mid-refill returns to IDLE with lines cleared.
        miss(32'h0000_6000);
        rst = 1'b1;
        #1;
        chk("rst_mid_req_valid", 64'(bus.mem_req_valid_o), 64'd0);
        cycle();
        rst = 1'b0;
        bus.mem_resp_valid_i = 1'b1;
        bus.mem_resp_data_i  = DJ;
        cycle();
        bus.mem_resp_valid_i = 1'b0;
        miss(32'h0000_5000);
        refill(32'h0000_5000, D5, 0);
        hit(32'h0000_5004, D5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache_responder.md
Name: icache_responder

Overview:
- Instruction-cache responder on the fetch side of the IF stage.
- The IF stage issues one fetch request per cycle. This block answers each request one cycle later with either a hit (FETCH_WIDTH bits, i.e. 2 instructions) or a miss.
- It owns a small direct-mapped line array. On a miss it runs a single-outstanding refill FSM toward the lower memory.

Parameters:
- PC_BITS, 32, fetch address width.
- FETCH_WIDTH, 64, line and response width in bits (one line = one fetch packet).
- INSTR_BITS, 32, instruction width.
- ICACHE_LINES, 16, number of direct-mapped lines; must be a power of 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid_i  in  1  fetch request valid.
- req_addr_i  in  PC_BITS  fetch PC, 4-byte aligned.
- flush_i  in  1  pipeline flush/restart; kills the pending response.
- inv_all_i  in  1  invalidate every line.
- resp_valid_o  out  1  hit response valid.
- resp_miss_o  out  1  miss response.
- resp_pc_o  out  PC_BITS  PC of the answered request.
- resp_data_o  out  FETCH_WIDTH  fetched instructions; instruction at resp_pc_o is in bits [31:0].
- resp_partial_o  out  1  only bits [31:0] are meaningful (PC was in the upper half of the line).
- mem_req_valid_o  out  1  refill request.
- mem_req_addr_o  out  PC_BITS  line-aligned refill address.
- mem_req_ready_i  in  1  memory accepts request.
- mem_resp_valid_i  in  1  refill data valid (single beat).
- mem_resp_data_i  in  FETCH_WIDTH  refill line.

Behaviour:
- Address split:
  - offset = addr[2:0]
  - index = addr[3+log2(ICACHE_LINES)-1:3]
  - tag = remaining upper bits.
- Reset state:
  - all outputs 0
  - all line valid bits cleared
  - FSM in IDLE
  - poison flag cleared.
- Lookup timing:
  - A request at edge N is looked up against array state before edge N.
  - The response is registered and visible in cycle N+1.
  - There is no bypass of a refill written in the same cycle.
- Hit (valid && tag match):
  - resp_valid_o=1, resp_miss_o=0.
  - resp_data_o = line when addr[2]=0, resp_partial_o=0.
  - When addr[2]=1: resp_data_o = {32'b0, line[63:32]}, resp_partial_o=1.
- Miss:
  - resp_miss_o=1, resp_valid_o=0, resp_data_o=0.
  - resp_pc_o is always the request PC.
- No request: resp_valid_o=0, resp_miss_o=0.
- flush_i high at edge N: registered response forced to 0, and the request presented in that cycle is dropped (no response, no refill started).
- FSM states:
  - IDLE: a miss at an edge captures the line address and moves to REQ. A flushed request never starts a refill.
  - REQ: mem_req_valid_o=1 with mem_req_addr_o held stable; go to WAIT when mem_req_ready_i=1 at an edge.
  - WAIT: on mem_resp_valid_i, write data, tag and valid=1 into the line unless poisoned; clear poison; go to IDLE.
- Misses while FSM is not IDLE:
  - answered as miss; no second refill is started.
  - this includes a miss to the line currently being refilled.
  - IF retries such requests.
- inv_all_i at an edge:
  - clears all valid bits.
  - if FSM is in REQ or WAIT, sets poison; the returning line is discarded.
  - if inv_all_i coincides with mem_resp_valid_i, the line is not installed.
- inv_all_i coinciding with a lookup: the lookup uses pre-invalidate state.
- Refill write and a lookup to the same index in the same cycle: the lookup sees the old contents.
- Asynchronous reset mid-refill: FSM returns to IDLE. A later mem_resp_valid_i arriving in IDLE is ignored.
- mem_req_ready_i is don't-care outside REQ. mem_resp_valid_i is ignored outside WAIT.

Decomposition:
- Shared package util_pkg gains:
  - icache_state_e (IDLE, REQ, WAIT)
  - icache_req_s {valid, addr}
  - icache_resp_s {valid, miss, partial, pc, data}
  - icache_line_s {valid, tag, data}
  - constant ICACHE_LINES.
- Sub-module icache_line_array:
  - holds the tag, data and valid storage.
  - one combinational read port, one write port.
  - a clear-all input for the valid bits.
- icache_responder keeps the FSM, poison flag and response registers.

Test Plan:
1. Cold miss then refill:
   - After reset, req 0x0000_1000 -> next cycle resp_miss_o=1.
   - FSM raises mem_req_valid_o with addr 0x0000_1000; ready=1.
   - 3 cycles later mem_resp_data_i=0x0000_0013_0000_0093.
   - Retried req 0x1000 -> resp_valid_o=1, data 0x0000_0013_0000_0093, partial=0.
2. Partial access: req 0x0000_1004 after test 1 -> resp_valid_o=1, resp_data_o=0x0000_0000_0000_0013, resp_partial_o=1.
3. Conflict eviction: req 0x0000_1080 (same index 0, new tag) -> miss and refill with 0xAAAA_AAAA_BBBB_BBBB; then req 0x1000 -> miss again.
4. Flush: hit req 0x1000 with flush_i=1 in the same cycle -> resp_valid_o=0, resp_miss_o=0 next cycle. Flushed missing req 0x2000 -> mem_req_valid_o stays 0.
5. Invalidate mid-refill:
   - Miss 0x3000; assert inv_all_i while in WAIT; then return data.
   - Req 0x3000 -> miss, new refill issued.
   - Req 0x1000 -> miss.
6. Busy miss:
   - While refilling 0x1000 (mem_req_ready_i=0 for 5 cycles), req 0x4000 -> resp_miss_o=1.
   - mem_req_addr_o stays 0x1000; only one mem request is issued until return to IDLE.
